// File: rtl/lpgbt_deinterleaver_pkg.sv
// Shared definitions for the lpGBT downlink deinterleaver.
// Provides:
//   - the default geometry parameters;
//   - width helpers used to derive FEC_W, DATA_W and HDR_W;
//   - the two bit-offset functions that describe the symbol mapping.
// The pipeline top and the mapping sub-module both use this package, so they
// always agree on the frame layout.
package lpgbt_deinterleaver_pkg;

  localparam int NUM_CODES_DEF  = 4;
  localparam int SYM_BITS_DEF   = 3;
  localparam int DATA_SYMS_DEF  = 3;
  localparam int FEC_SYMS_DEF   = 2;
  localparam int FRAME_BITS_DEF = 64;

  // Width of a region that holds num_codes codewords of syms symbols each.
  function automatic int field_width(input int num_codes, input int syms,
                                     input int sym_bits);
    return num_codes * syms * sym_bits;
  endfunction

  // Bit offset, inside a received (interleaved) region, of symbol s of code c.
  // On the line, symbol 0 of every code comes first, then symbol 1 of every
  // code, and so on.
  function automatic int ilv_offset(input int s, input int c,
                                    input int num_codes, input int sym_bits);
    return (s * num_codes + c) * sym_bits;
  endfunction

  // Bit offset, inside a deinterleaved output region, of symbol s of code c.
  // Each codeword occupies a contiguous field; symbol s sits at s*sym_bits
  // inside that field.
  function automatic int cw_offset(input int c, input int s,
                                   input int syms, input int sym_bits);
    return (c * syms + s) * sym_bits;
  endfunction

endpackage

// File: rtl/lpgbt_deinterleaver_map.sv
// Combinational symbol mapping for one downlink frame.
// Ports:
//   frame  : received frame, laid out as {hdr, data region, fec region}
//   bypass : 1 = frame is not interleaved, so regions are copied unpermuted
//   data   : deinterleaved data field, codeword c at [c*DATA_SYMS*SYM_BITS +:]
//   fec    : deinterleaved FEC field,  codeword c at [c*FEC_SYMS*SYM_BITS +:]
//   hdr    : frame bits above the FEC and data regions, passed through
module lpgbt_deinterleaver_map
  import lpgbt_deinterleaver_pkg::*;
#(
  parameter int NUM_CODES  = NUM_CODES_DEF,
  parameter int SYM_BITS   = SYM_BITS_DEF,
  parameter int DATA_SYMS  = DATA_SYMS_DEF,
  parameter int FEC_SYMS   = FEC_SYMS_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  localparam int FEC_W  = field_width(NUM_CODES, FEC_SYMS, SYM_BITS),
  localparam int DATA_W = field_width(NUM_CODES, DATA_SYMS, SYM_BITS),
  localparam int HDR_W  = FRAME_BITS - FEC_W - DATA_W
) (
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  bypass,
  output logic [DATA_W-1:0]     data,
  output logic [FEC_W-1:0]      fec,
  output logic [HDR_W-1:0]      hdr
);

  always_comb begin
    data = '0;
    fec  = '0;
    if (bypass) begin
      fec  = frame[FEC_W-1:0];
      data = frame[FEC_W +: DATA_W];
    end else begin
      for (int c = 0; c < NUM_CODES; c++) begin
        for (int s = 0; s < FEC_SYMS; s++) begin
          fec[cw_offset(c, s, FEC_SYMS, SYM_BITS) +: SYM_BITS] =
            frame[ilv_offset(s, c, NUM_CODES, SYM_BITS) +: SYM_BITS];
        end
        for (int s = 0; s < DATA_SYMS; s++) begin
          data[cw_offset(c, s, DATA_SYMS, SYM_BITS) +: SYM_BITS] =
            frame[FEC_W + ilv_offset(s, c, NUM_CODES, SYM_BITS) +: SYM_BITS];
        end
      end
    end
  end

  assign hdr = frame[FRAME_BITS-1 -: HDR_W];

endmodule

// File: rtl/lpgbt_deinterleaver_pipe.sv
// Pipelined lpGBT downlink deinterleaver.
// Datapath: S1 (raw frame + bypass flag) -> map -> S2 (mapped result) -> skid.
// The output is driven from the skid entry when it is occupied, else from S2.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready is registered)
//   in_frame, in_bypass : frame and its per-frame bypass flag
//   out_valid/out_ready : output handshake
//   out_data/fec/hdr    : deinterleaved frame
//   frame_cnt           : accepted frames, wraps
//   drop_cnt            : cycles with in_valid while not ready, saturates
module lpgbt_deinterleaver_pipe
  import lpgbt_deinterleaver_pkg::*;
#(
  parameter int NUM_CODES  = NUM_CODES_DEF,
  parameter int SYM_BITS   = SYM_BITS_DEF,
  parameter int DATA_SYMS  = DATA_SYMS_DEF,
  parameter int FEC_SYMS   = FEC_SYMS_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  localparam int FEC_W  = field_width(NUM_CODES, FEC_SYMS, SYM_BITS),
  localparam int DATA_W = field_width(NUM_CODES, DATA_SYMS, SYM_BITS),
  localparam int HDR_W  = FRAME_BITS - FEC_W - DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FRAME_BITS-1:0] in_frame,
  input  logic                  in_bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [FEC_W-1:0]      out_fec,
  output logic [HDR_W-1:0]      out_hdr,
  output logic [15:0]           frame_cnt,
  output logic [7:0]            drop_cnt
);

  if (FRAME_BITS < FEC_W + DATA_W) begin : g_bad_frame_bits
    $error("FRAME_BITS is smaller than the FEC and data regions combined");
  end

  logic                  s1_v, s2_v, sk_v;
  logic [FRAME_BITS-1:0] s1_frame;
  logic                  s1_bypass;
  logic [DATA_W-1:0]     s2_data, sk_data, map_data;
  logic [FEC_W-1:0]      s2_fec, sk_fec, map_fec;
  logic [HDR_W-1:0]      s2_hdr, sk_hdr, map_hdr;

  logic in_fire, s2_free, s1_adv, sk_load;
  logic s1_v_nxt, s2_v_nxt, sk_v_nxt;

  lpgbt_deinterleaver_map #(
    .NUM_CODES (NUM_CODES),
    .SYM_BITS  (SYM_BITS),
    .DATA_SYMS (DATA_SYMS),
    .FEC_SYMS  (FEC_SYMS),
    .FRAME_BITS(FRAME_BITS)
  ) u_map (
    .frame (s1_frame),
    .bypass(s1_bypass),
    .data  (map_data),
    .fec   (map_fec),
    .hdr   (map_hdr)
  );

  // S2 always vacates when the skid is empty: either its frame leaves on the
  // output (out_ready=1) or it parks in the skid (out_ready=0). That makes
  // S2's availability a function of registers only, which keeps out_ready
  // out of every ready path.
  assign in_fire = in_valid && in_ready;
  assign s2_free = !s2_v || !sk_v;
  assign s1_adv  = s1_v && s2_free;
  assign sk_load = s2_v && !sk_v && !out_ready;

  assign s1_v_nxt = in_fire || (s1_v && !s1_adv);
  assign s2_v_nxt = s1_adv || (s2_v && !s2_free);
  assign sk_v_nxt = sk_v ? !out_ready : sk_load;

  // The skid always holds the older frame, so it is presented first.
  assign out_valid = sk_v || s2_v;
  assign out_data  = sk_v ? sk_data : s2_data;
  assign out_fec   = sk_v ? sk_fec  : s2_fec;
  assign out_hdr   = sk_v ? sk_hdr  : s2_hdr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      sk_v      <= 1'b0;
      in_ready  <= 1'b0;
      s1_frame  <= '0;
      s1_bypass <= 1'b0;
      s2_data   <= '0;
      s2_fec    <= '0;
      s2_hdr    <= '0;
      sk_data   <= '0;
      sk_fec    <= '0;
      sk_hdr    <= '0;
    end else begin
      s1_v     <= s1_v_nxt;
      s2_v     <= s2_v_nxt;
      sk_v     <= sk_v_nxt;
      // Ready for the next cycle unless all three slots will be occupied.
      in_ready <= !(s1_v_nxt && s2_v_nxt && sk_v_nxt);
      if (in_fire) begin
        s1_frame  <= in_frame;
        s1_bypass <= in_bypass;
      end
      if (s1_adv) begin
        s2_data <= map_data;
        s2_fec  <= map_fec;
        s2_hdr  <= map_hdr;
      end
      if (sk_load) begin
        sk_data <= s2_data;
        sk_fec  <= s2_fec;
        sk_hdr  <= s2_hdr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (in_fire) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (in_valid && !in_ready && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lpgbt_deinterleaver_pipe.sv
// Self-checking bench for lpgbt_deinterleaver_pipe (default parameters).
// Directed vectors from a table, then multi-cycle sequences: latency,
// 100 back-to-back frames, output stall with skid fill, and reset while
// frames are held. Outputs are checked through a scoreboard queue.
module tb_lpgbt_deinterleaver_pipe;

  localparam int NC = 4, SB = 3, DS = 3, FS = 2, FB = 64;
  localparam int FEC_W  = NC * FS * SB;
  localparam int DATA_W = NC * DS * SB;
  localparam int HDR_W  = FB - FEC_W - DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FB-1:0]     in_frame = '0;
  logic              in_bypass = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [FEC_W-1:0]  out_fec;
  logic [HDR_W-1:0]  out_hdr;
  logic [15:0]       frame_cnt;
  logic [7:0]        drop_cnt;

  always #5 clk = ~clk;

  lpgbt_deinterleaver_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_frame (in_frame),
    .in_bypass(in_bypass),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_fec  (out_fec),
    .out_hdr  (out_hdr),
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [FEC_W-1:0]  fec;
    logic [HDR_W-1:0]  hdr;
  } exp_t;

  typedef struct {
    logic [FB-1:0]     frame;
    logic              bypass;
    logic [DATA_W-1:0] data;
    logic [FEC_W-1:0]  fec;
    logic [HDR_W-1:0]  hdr;
  } vec_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   n_stall = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference mapping, written from the receive side: walk the received
  // symbols in line order and drop each one into its codeword slot.
  function automatic exp_t model(input logic [FB-1:0] f, input logic byp);
    exp_t e;
    e.data = '0;
    e.fec  = '0;
    e.hdr  = f[FB-1 -: HDR_W];
    if (byp) begin
      e.fec  = f[FEC_W-1:0];
      e.data = f[FEC_W +: DATA_W];
    end else begin
      for (int k = 0; k < NC * FS; k++)
        e.fec[((k % NC) * FS + k / NC) * SB +: SB] = f[k * SB +: SB];
      for (int k = 0; k < NC * DS; k++)
        e.data[((k % NC) * DS + k / NC) * SB +: SB] = f[FEC_W + k * SB +: SB];
    end
    return e;
  endfunction

  // Output monitor: sampled on the falling edge, where outputs and
  // out_ready are settled for the coming rising edge.
  logic held = 1'b0;
  exp_t held_v;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", 64'(out_data), 64'(held_v.data));
          check("stall_fec",  64'(out_fec),  64'(held_v.fec));
          check("stall_hdr",  64'(out_hdr),  64'(held_v.hdr));
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (sb_q.size() == 0) begin
            check("unexpected_out", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_fec",  64'(out_fec),  64'(e.fec));
            check("out_hdr",  64'(out_hdr),  64'(e.hdr));
          end
        end
        held        = out_valid && !out_ready;
        held_v.data = out_data;
        held_v.fec  = out_fec;
        held_v.hdr  = out_hdr;
      end
    end
  end

  // Called at rising edge + 1; returns at rising edge + 1 after acceptance.
  task automatic send(input logic [FB-1:0] f, input logic byp, input exp_t e);
    in_valid  = 1'b1;
    in_frame  = f;
    in_bypass = byp;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_bypass = 1'($urandom_range(1, 0));
        return;
      end
      n_stall++;
      @(posedge clk);
      #1;
    end
    check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(posedge clk);
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset away from any clock edge and checks the immediate effect.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_drop_cnt",  64'(drop_cnt),  64'd0);
    check("rst_payload", 64'({out_hdr, out_fec} | 64'(out_data)), 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl[9];
  initial begin
    logic [FB-1:0] f;
    logic [FB-1:0] sf[5];
    logic          sbyp[5];
    exp_t          e;
    int            idx, s0, o0;

    tbl[0] = '{64'h0000_0010_0000_0000, 1'b0, 36'h8,            24'h0,      4'h0};
    tbl[1] = '{64'h0000_0010_0000_0000, 1'b1, 36'h1000,         24'h0,      4'h0};
    tbl[2] = '{64'h0000_0000_0000_1000, 1'b1, 36'h0,            24'h1000,   4'h0};
    tbl[3] = '{64'h0000_0000_0000_1000, 1'b0, 36'h0,            24'h8,      4'h0};
    tbl[4] = '{64'hF000_0000_0000_0000, 1'b0, 36'h0,            24'h0,      4'hF};
    tbl[5] = '{64'hF000_0000_0000_0000, 1'b1, 36'h0,            24'h0,      4'hF};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 36'hF_FFFF_FFFF,  24'hFF_FFFF, 4'hF};
    tbl[7] = '{64'h0000_0000_0800_0008, 1'b0, 36'h200,          24'h40,     4'h0};
    tbl[8] = '{64'h0A00_0000_0000_0000, 1'b0, 36'hA_0000_0000,  24'h0,      4'h0};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed vectors, back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      e.data = tbl[i].data;
      e.fec  = tbl[i].fec;
      e.hdr  = tbl[i].hdr;
      send(tbl[i].frame, tbl[i].bypass, e);
    end
    drain();

    // Latency from input handshake to out_valid.
    f = {$urandom, $urandom};
    in_valid = 1'b1; in_frame = f; in_bypass = 1'b0;
    @(negedge clk);
    check("lat_in_ready", 64'(in_ready), 64'd1);
    sb_q.push_back(model(f, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    drain();

    // 100 back-to-back frames with random bypass.
    do_reset();
    out_ready = 1'b1;
    s0 = n_stall;
    o0 = n_out;
    for (int i = 0; i < 100; i++) begin
      logic b;
      f = {$urandom, $urandom};
      b = 1'($urandom_range(1, 0));
      send(f, b, model(f, b));
    end
    check("b2b_stalls", 64'(n_stall - s0), 64'd0);
    check("b2b_frame_cnt", 64'(frame_cnt), 64'd100);
    drain();
    check("b2b_outputs", 64'(n_out - o0), 64'd100);
    check("b2b_drop_cnt", 64'(drop_cnt), 64'd0);

    // Output stalled while 5 frames are offered over 8 cycles.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sf[i]   = {$urandom, $urandom};
      sbyp[i] = 1'($urandom_range(1, 0));
    end
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; in_frame = sf[0]; in_bypass = sbyp[0];
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (in_ready && idx < 5) begin
        sb_q.push_back(model(sf[idx], sbyp[idx]));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 5) begin
        in_frame  = sf[idx];
        in_bypass = sbyp[idx];
      end else begin
        in_bypass = ~in_bypass;
      end
    end
    in_valid = 1'b0;
    in_bypass = ~in_bypass;
    check("stall_accepted", 64'(idx), 64'd3);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_frame_cnt", 64'(frame_cnt), 64'd3);
    check("stall_drop_cnt", 64'(drop_cnt), 64'd5);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    o0 = n_out;
    out_ready = 1'b1;
    drain();
    check("stall_outputs", 64'(n_out - o0), 64'd3);

    // Reset while two frames are held.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      f = {$urandom, $urandom};
      send(f, 1'b0, model(f, 1'b0));
    end
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    do_reset();
    out_ready = 1'b1;
    o0 = n_out;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_out", 64'(n_out - o0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
